pwm_drive: RTL and testbench

Downstream stage of the PID controller. Converts the signed, saturated PID command into complementary-direction H-bridge gate drive. Each fixed-length PWM period latches a new command. Direction reversal and every activation from idle are separated by a programmable dead time. Output is sign/magnitude: `pwm_a` drives forward, `pwm_b` drives reverse, and they are never high together.

---
 rtl/pwm_drive.sv | 132 +++++++++++++
 tb/tb_pwm_drive.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pwm_drive.sv
// Sign/magnitude H-bridge PWM driver fed by the PID command.
// One command latch per period; dead time on every activation and direction change.
module pwm_drive #(
  parameter int unsigned D_WIDTH  = 16,
  parameter int unsigned PERIOD   = 100,
  parameter int unsigned DEADTIME = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] cmd,
  output logic               pwm_a,
  output logic               pwm_b,
  output logic               dir,
  output logic               dead_active,
  output logic               period_start
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned MW = $clog2(PERIOD + 1);
  localparam int unsigned DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  localparam logic [CW-1:0] CntLast  = CW'(PERIOD - 1);
  localparam logic [MW-1:0] MagMax   = MW'(PERIOD);
  localparam logic [DW-1:0] DeadLast = (DEADTIME > 0) ? DW'(DEADTIME - 1) : '0;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFwd  = 2'd1;
  localparam logic [1:0] StRev  = 2'd2;
  localparam logic [1:0] StDead = 2'd3;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [MW-1:0] mag_q, mag_d;
  logic          dir_q, dir_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic          period_start_q;

  logic             boundary;
  logic [D_WIDTH:0] cmd_ext;
  logic [D_WIDTH:0] cmd_abs;
  logic [MW-1:0]    mag_new;
  logic             new_dir;
  logic             mag_nz;
  logic             start_move;

  assign boundary = (cnt_q == CntLast);
  assign new_dir  = cmd[D_WIDTH-1];

  // One extra bit so the most negative command has a representable magnitude.
  assign cmd_ext = {cmd[D_WIDTH-1], cmd};

  always_comb begin
    cmd_abs = new_dir ? -cmd_ext : cmd_ext;
    if (32'(cmd_abs) > PERIOD) begin
      mag_new = MagMax;
    end else begin
      mag_new = MW'(cmd_abs);
    end
  end

  assign mag_nz = (mag_new != '0);
  assign cnt_d  = boundary ? '0 : cnt_q + CW'(1);
  assign mag_d  = boundary ? mag_new : mag_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    dead_cnt_d = dead_cnt_q;
    start_move = 1'b0;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: start_move = boundary && mag_nz;
        StFwd, StRev: start_move = boundary && mag_nz && (new_dir != dir_q);
        StDead: begin
          // A reversal during dead time restarts the full dead interval.
          if (boundary && mag_nz && (new_dir != pend_q)) begin
            start_move = 1'b1;
          end else if (dead_cnt_q == DeadLast) begin
            state_d = pend_q ? StRev : StFwd;
            dir_d   = pend_q;
          end else begin
            dead_cnt_d = dead_cnt_q + DW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (start_move) begin
      if (DEADTIME > 0) begin
        state_d    = StDead;
        pend_d     = new_dir;
        dead_cnt_d = '0;
      end else begin
        state_d = new_dir ? StRev : StFwd;
        dir_d   = new_dir;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q          <= '0;
      state_q        <= StIdle;
      mag_q          <= '0;
      dir_q          <= 1'b0;
      pend_q         <= 1'b0;
      dead_cnt_q     <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      mag_q          <= mag_d;
      dir_q          <= dir_d;
      pend_q         <= pend_d;
      dead_cnt_q     <= dead_cnt_d;
      period_start_q <= boundary;
    end
  end

  // The compare runs off the free counter, so on-time lost to dead time is not recovered.
  assign pwm_a        = (state_q == StFwd) && (MW'(cnt_q) < mag_q);
  assign pwm_b        = (state_q == StRev) && (MW'(cnt_q) < mag_q);
  assign dir          = dir_q;
  assign dead_active  = (state_q == StDead);
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_drive.sv
// Directed bench for pwm_drive: one DUT with dead time 4, one with dead time 0.
module tb_pwm_drive;

  localparam int P = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] cmd;
  logic        pwm_a0, pwm_b0, dir0, dead0, ps0;
  logic        pwm_a1, pwm_b1, dir1, dead1, ps1;

  int vectors = 0;
  int errors  = 0;
  int pos     = 0;
  bit ps_armed = 1'b0;
  bit inv_on   = 1'b0;

  always #5 clock = ~clock;

  pwm_drive #(.D_WIDTH(16), .PERIOD(P), .DEADTIME(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .cmd          (cmd),
    .pwm_a        (pwm_a0),
    .pwm_b        (pwm_b0),
    .dir          (dir0),
    .dead_active  (dead0),
    .period_start (ps0)
  );

  pwm_drive #(.D_WIDTH(16), .PERIOD(P), .DEADTIME(0)) dut_nodead (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .cmd          (cmd),
    .pwm_a        (pwm_a1),
    .pwm_b        (pwm_b1),
    .dir          (dir1),
    .dead_active  (dead1),
    .period_start (ps1)
  );

  // Both drive outputs high together is never allowed.
  always @(negedge clock) begin
    if (inv_on) begin
      vectors++;
      assert (!(pwm_a0 && pwm_b0) && !(pwm_a1 && pwm_b1)) else begin
        errors++;
        $error("FAIL overlap cnt=%0d observed a0b0=%b%b a1b1=%b%b expected no overlap",
               pos, pwm_a0, pwm_b0, pwm_a1, pwm_b1);
      end
    end
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cnt=%0d observed=%b expected=%b", tag, pos, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (pos == P - 1) begin
      pos = 0;
      ps_armed = 1'b1;
    end else begin
      pos++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pos = 0;
    ps_armed = 1'b0;
  endtask

  // Check {pwm_a, pwm_b, dead_active, period_start} each cycle from pos up to c_end.
  task automatic span(input string tag, input int which, input int c_end,
                      input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                      input int d_hi);
    bit last;
    logic [3:0] obs, exp;
    do begin
      exp = {(pos >= a_lo) && (pos < a_hi), (pos >= b_lo) && (pos < b_hi), pos < d_hi,
             (pos == 0) && ps_armed};
      obs = (which == 0) ? {pwm_a0, pwm_b0, dead0, ps0} : {pwm_a1, pwm_b1, dead1, ps1};
      chk(tag, obs, exp);
      last = (pos == c_end);
      tick();
    end while (!last);
  endtask

  initial begin
    enable = 1'b0;
    cmd    = 16'd0;
    do_reset();
    inv_on = 1'b1;
    chk("reset_outs", {pwm_a0, pwm_b0, dead0, ps0}, 4'b0000);
    chk("reset_dir", {3'b000, dir0}, 4'b0000);

    // Start-up from idle
    enable = 1'b1;
    cmd    = 16'd40;
    span("t1_first", 0, P - 1, 0, 0, 0, 0, 0);
    span("t1_dead", 0, P - 1, 4, 40, 0, 0, 4);
    span("t1_steady", 0, P - 1, 0, 40, 0, 0, 0);
    chk("t1_dir", {3'b000, dir0}, 4'b0000);

    // Reversal
    cmd = -16'sd25;
    span("t2_old", 0, P - 1, 0, 40, 0, 0, 0);
    span("t2_dead", 0, P - 1, 0, 0, 4, 25, 4);
    chk("t2_dir", {3'b000, dir0}, 4'b0001);
    span("t2_steady", 0, P - 1, 0, 0, 0, 25, 0);

    // Saturation
    cmd = 16'd300;
    span("t3_old", 0, P - 1, 0, 0, 0, 25, 0);
    span("t3_fwd_dead", 0, P - 1, 4, P, 0, 0, 4);
    cmd = 16'h8000;
    span("t3_fwd_full", 0, P - 1, 0, P, 0, 0, 0);
    span("t3_rev_dead", 0, P - 1, 0, 0, 4, P, 4);
    chk("t3_dir", {3'b000, dir0}, 4'b0001);

    // Mid-period command change
    cmd = 16'd40;
    span("t4_rev_full", 0, P - 1, 0, 0, 0, P, 0);
    span("t4_dead", 0, P - 1, 4, 40, 0, 0, 4);
    span("t4_pre50", 0, 49, 0, 40, 0, 0, 0);
    cmd = 16'd10;
    span("t4_post50", 0, P - 1, 0, 40, 0, 0, 0);
    cmd = 16'd0;
    span("t4_ten", 0, P - 1, 0, 10, 0, 0, 0);
    cmd = 16'd30;
    span("t4_zero", 0, P - 1, 0, 0, 0, 0, 0);
    chk("t4_dir_held", {3'b000, dir0}, 4'b0000);
    cmd = 16'd40;
    span("t4_thirty", 0, P - 1, 0, 30, 0, 0, 0);

    // Enable toggle
    span("t5_pre", 0, 19, 0, 40, 0, 0, 0);
    enable = 1'b0;
    span("t5_at20", 0, 20, 0, 40, 0, 0, 0);
    span("t5_off", 0, 59, 0, 0, 0, 0, 0);
    enable = 1'b1;
    span("t5_reenable", 0, P - 1, 0, 0, 0, 0, 0);
    span("t5_dead", 0, P - 1, 4, 40, 0, 0, 4);
    chk("t5_dir", {3'b000, dir0}, 4'b0000);

    // Mid-period reset
    span("t6_pre", 0, 29, 0, 40, 0, 0, 0);
    chk("t6_at30", {pwm_a0, pwm_b0, dead0, ps0}, 4'b1000);
    do_reset();
    chk("t6_rst_outs", {pwm_a0, pwm_b0, dead0, ps0}, 4'b0000);
    chk("t6_rst_nodead", {pwm_a1, pwm_b1, dead1, ps1}, 4'b0000);
    span("t6_first", 0, P - 1, 0, 0, 0, 0, 0);

    // Dead time disabled: direct activation and reversal
    cmd = -16'sd40;
    span("t6_nd_fwd", 1, P - 1, 0, 40, 0, 0, 0);
    span("t6_nd_rev", 1, P - 1, 0, 0, 0, 40, 0);
    chk("t6_nd_dir", {3'b000, dir1}, 4'b0001);
    span("t6_nd_steady", 1, P - 1, 0, 0, 0, 40, 0);

    inv_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
